mult_shift_add: RTL



---
 rtl/mult_shift_add_pkg.sv | 8 +
 rtl/mult_shift_add_datapath.sv | 39 +++
 rtl/mult_shift_add.sv | 53 +++++
 3 files changed

// File: rtl/mult_shift_add_pkg.sv
// mult_shift_add_pkg: controller state encoding shared by the multiplier files
package mult_shift_add_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mult_shift_add_datapath.sv
// mult_datapath: multiplicand/accumulator registers, ripple adder and right shift
module mult_datapath #(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] acc_shift
);
  logic [N-1:0] mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d, addend, sum;
  logic [N:0]   c;
  assign addend = lo_q[0] ? mcand_q : '0;
  assign c[0]   = 1'b0;
  for (genvar i = 0; i < N; i++) begin : g_rca
    assign sum[i]   = hi_q[i] ^ addend[i] ^ c[i];
    assign c[i+1]   = (hi_q[i] & addend[i]) | (c[i] & (hi_q[i] ^ addend[i]));
  end
  // carry-out becomes the new MSB; without it (2^N-1)^2 comes out wrong
  assign acc_shift = {c[N], sum, lo_q[N-1:1]};
  always_comb begin
    mcand_d = load ? a : mcand_q;
    hi_d    = load ? '0 : step ? acc_shift[2*N-1:N] : hi_q;
    lo_d    = load ? b : step ? acc_shift[N-1:0] : lo_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: rtl/mult_shift_add.sv
// mult_shift_add: sequential unsigned NxN shift-and-add multiplier with start/done handshake
module mult_shift_add
  import mult_shift_add_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);
  localparam int CW = $clog2(N) + 1;
  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2*N-1:0]  p_q, p_d, acc_shift;
  logic            load, step, last;
  mult_datapath #(.N(N)) u_dp (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .step      (step),
    .a         (a),
    .b         (b),
    .acc_shift (acc_shift)
  );
  // DONE and the unused encoding both fall back to IDLE
  always_comb begin
    load    = (state_q == ST_IDLE) && start;
    step    = (state_q == ST_CALC);
    last    = step && (count_q == CW'(N - 1));
    state_d = load ? ST_CALC : step ? (last ? ST_DONE : ST_CALC) : ST_IDLE;
    count_d = load ? '0 : step ? count_q + CW'(1) : count_q;
    p_d     = last ? acc_shift : p_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
    end
  end
  assign busy = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign done = (state_q == ST_DONE);
  assign p    = p_q;
endmodule
